// File: rtl/rpsc_uart_pkg.sv
// Shared constants and state encodings for the RPSC status UART reporter.
// Holds the frame sync byte, the shortened simulation timing constants and
// the enumerations for the byte-level and frame-level state machines.
package rpsc_uart_pkg;

    localparam logic [7:0] SYNC_BYTE         = 8'hA5;
    localparam int         TEST_CLKS_PER_BIT = 4;
    localparam int         TEST_HEARTBEAT    = 64;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } txState_e;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_SEND,
        FR_DONE
    } frameState_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser for the RPSC status reporter.
// Ports:
//   clk      block clock
//   reset    synchronous, active-high
//   i_data   byte to transmit, sampled when i_valid && o_ready
//   i_valid  a byte is offered
//   o_ready  engine can take a byte this cycle (idle, or final stop-bit cycle)
//   o_tx     serial line, idles high
module uart_tx_byte
    import rpsc_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    txState_e          r_state;
    txState_e          w_stateNext;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baudNext;
    logic [2:0]        r_bitCnt;
    logic [2:0]        w_bitCntNext;
    logic [7:0]        r_shift;
    logic [7:0]        w_shiftNext;
    logic              r_tx;
    logic              w_txNext;
    logic              w_bitEnd;
    logic              w_accept;

    assign w_bitEnd = (r_baud == BAUD_LAST);
    // Ready in the last stop-bit cycle lets the next start bit follow with no gap.
    assign o_ready  = (r_state == TX_IDLE) || ((r_state == TX_STOP) && w_bitEnd);
    assign w_accept = i_valid && o_ready;
    assign o_tx     = r_tx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= TX_IDLE;
            r_baud   <= '0;
            r_bitCnt <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_stateNext;
            r_baud   <= w_baudNext;
            r_bitCnt <= w_bitCntNext;
            r_shift  <= w_shiftNext;
            r_tx     <= w_txNext;
        end
    end

    // The line value is registered one cycle ahead, so every bit is held for
    // exactly CLKS_PER_BIT cycles starting the cycle after it is decided.
    always_comb begin
        w_stateNext  = r_state;
        w_baudNext   = w_bitEnd ? '0 : r_baud + 1'b1;
        w_bitCntNext = r_bitCnt;
        w_shiftNext  = r_shift;
        w_txNext     = r_tx;
        case (r_state)
            TX_IDLE: begin
                w_baudNext = '0;
                w_txNext   = 1'b1;
            end
            TX_START: begin
                if (w_bitEnd) begin
                    w_stateNext  = TX_DATA;
                    w_bitCntNext = '0;
                    w_txNext     = r_shift[0];
                end
            end
            TX_DATA: begin
                if (w_bitEnd) begin
                    if (r_bitCnt == 3'd7) begin
                        w_stateNext = TX_STOP;
                        w_txNext    = 1'b1;
                    end else begin
                        w_bitCntNext = r_bitCnt + 3'd1;
                        w_shiftNext  = {1'b0, r_shift[7:1]};
                        w_txNext     = r_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (w_bitEnd) begin
                    w_stateNext = TX_IDLE;
                    w_txNext    = 1'b1;
                end
            end
            default: begin
                w_stateNext = TX_IDLE;
                w_txNext    = 1'b1;
            end
        endcase
        if (w_accept) begin
            w_stateNext = TX_START;
            w_baudNext  = '0;
            w_shiftNext = i_data;
            w_txNext    = 1'b0;
        end
    end

endmodule

// File: rtl/rpsc_status_uart_tx.sv
// RPSC status reporter: snapshots the lamp/alarm status vector and sends it
// to the host as an 8N1 frame: A5, seq, payload bytes (byte 0 first), chk,
// where chk is the XOR of seq and the payload bytes.
// A frame is sent after reset, on i_send_req, on a status change seen while
// not sending, and on heartbeat expiry while idle.
// Ports:
//   clk           block clock (same divided clock as the card logic)
//   reset         synchronous, active-high
//   i_status      live status vector, byte k = bits [8k+7:8k]
//   i_send_req    single-cycle frame request
//   o_UART_TX     serial line, idles high
//   o_busy        high for the whole frame on the line
//   o_frame_done  one-cycle pulse after the final stop bit
module rpsc_status_uart_tx
    import rpsc_uart_pkg::*;
#(
    parameter int test_mode        = 0,
    parameter int CLKS_PER_BIT     = 434,
    parameter int STATUS_BYTES     = 8,
    parameter int HEARTBEAT_CYCLES = 50_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [8*STATUS_BYTES-1:0] i_status,
    input  logic                      i_send_req,
    output logic                      o_UART_TX,
    output logic                      o_busy,
    output logic                      o_frame_done
);

    localparam int               CPB         = (test_mode != 0) ? TEST_CLKS_PER_BIT : CLKS_PER_BIT;
    localparam int               HB          = (test_mode != 0) ? TEST_HEARTBEAT : HEARTBEAT_CYCLES;
    localparam int               HB_W        = $clog2(HB + 1);
    localparam logic [HB_W-1:0]  HB_LAST     = HB_W'(HB - 1);
    localparam int               FRAME_BYTES = STATUS_BYTES + 3;
    localparam int               IDX_W       = $clog2(FRAME_BYTES + 1);
    localparam logic [IDX_W-1:0] IDX_CHK     = IDX_W'(FRAME_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_END     = IDX_W'(FRAME_BYTES);

    frameState_e               r_state;
    frameState_e               w_stateNext;
    logic                      r_pending;
    logic [HB_W-1:0]           r_hbCount;
    logic [7:0]                r_seq;
    logic [8*STATUS_BYTES-1:0] r_snapshot;
    logic [7:0]                r_chk;
    logic [IDX_W-1:0]          r_byteIdx;

    logic       w_start;
    logic       w_txValid;
    logic       w_txReady;
    logic [7:0] w_txData;
    logic       w_accept;
    logic       w_statusChanged;
    logic       w_hbExpire;

    assign w_statusChanged = (i_status != r_snapshot) && (r_state != FR_SEND);
    assign w_hbExpire      = (r_state == FR_IDLE) && (r_hbCount == HB_LAST);
    assign w_accept        = w_txValid && w_txReady;
    assign o_busy          = (r_state == FR_SEND);
    assign o_frame_done    = (r_state == FR_DONE);

    uart_tx_byte #(
        .CLKS_PER_BIT(CPB)
    ) u_txByte (
        .clk    (clk),
        .reset  (reset),
        .i_data (w_txData),
        .i_valid(w_txValid),
        .o_ready(w_txReady),
        .o_tx   (o_UART_TX)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FR_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // The sync byte is handed to the idle byte engine in the start cycle itself,
    // so the start bit appears on the line the very next cycle.
    always_comb begin
        w_stateNext = r_state;
        w_start     = 1'b0;
        w_txValid   = 1'b0;
        case (r_state)
            FR_IDLE: begin
                if (r_pending) begin
                    w_start     = 1'b1;
                    w_txValid   = 1'b1;
                    w_stateNext = FR_SEND;
                end
            end
            FR_SEND: begin
                w_txValid = (r_byteIdx != IDX_END);
                // With every byte handed over, ready only returns in the chk stop bit's last cycle.
                if (w_txReady && (r_byteIdx == IDX_END)) begin
                    w_stateNext = FR_DONE;
                end
            end
            FR_DONE: begin
                w_stateNext = FR_IDLE;
            end
            default: begin
                w_stateNext = FR_IDLE;
            end
        endcase
    end

    always_comb begin
        w_txData = SYNC_BYTE;
        if (!w_start) begin
            if (r_byteIdx == IDX_W'(1)) begin
                w_txData = r_seq;
            end else if (r_byteIdx == IDX_CHK) begin
                w_txData = r_chk;
            end else begin
                for (int k = 0; k < STATUS_BYTES; k++) begin
                    if (r_byteIdx == IDX_W'(k + 2)) begin
                        w_txData = r_snapshot[8*k +: 8];
                    end
                end
            end
        end
    end

    // r_byteIdx names the next byte to hand over; it restarts at 1 because
    // the sync byte leaves in the start cycle. r_chk folds in seq and payload
    // as they are handed over, and is itself sent as the last byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= 1'b1;
            r_hbCount  <= '0;
            r_seq      <= '0;
            r_snapshot <= '0;
            r_chk      <= '0;
            r_byteIdx  <= '0;
        end else if (w_start) begin
            r_snapshot <= i_status;
            r_pending  <= 1'b0;
            r_hbCount  <= '0;
            r_chk      <= '0;
            r_byteIdx  <= IDX_W'(1);
        end else begin
            if (i_send_req || w_statusChanged || w_hbExpire) begin
                r_pending <= 1'b1;
            end
            if (r_state == FR_IDLE) begin
                r_hbCount <= w_hbExpire ? '0 : r_hbCount + 1'b1;
            end
            if ((r_state == FR_SEND) && w_accept) begin
                r_byteIdx <= r_byteIdx + 1'b1;
                if (r_byteIdx != IDX_CHK) begin
                    r_chk <= r_chk ^ w_txData;
                end
            end
            if (r_state == FR_DONE) begin
                r_seq <= r_seq + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rpsc_status_uart_tx.sv
// Testbench for rpsc_status_uart_tx (test_mode=1, STATUS_BYTES=2).
// Stimulus pushes each expected frame into a queue when it triggers it; a
// line decoder pops and compares whole frames, checks bit timing, and a busy
// monitor checks frame length and the done pulse.
module tb_rpsc_status_uart_tx;

    localparam int SB           = 2;
    localparam int CPB          = 4;
    localparam int FRAME_BYTES  = SB + 3;
    localparam int FRAME_CYCLES = FRAME_BYTES * 10 * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] i_status;
    logic        i_send_req;
    logic        o_UART_TX;
    logic        o_busy;
    logic        o_frame_done;

    int          vectorCount = 0;
    int          missCount   = 0;
    logic [39:0] expQ[$];
    logic [7:0]  modelSeq;
    logic [15:0] curStatus;
    bit          timedOut = 1'b0;

    rpsc_status_uart_tx #(
        .test_mode       (1),
        .CLKS_PER_BIT    (4),
        .STATUS_BYTES    (SB),
        .HEARTBEAT_CYCLES(1000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_status    (i_status),
        .i_send_req  (i_send_req),
        .o_UART_TX   (o_UART_TX),
        .o_busy      (o_busy),
        .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    // Reference frame built straight from the frame definition.
    function automatic logic [39:0] makeFrame(input logic [7:0] seq, input logic [15:0] status);
        logic [39:0] f;
        logic [7:0]  chk;
        f       = '0;
        chk     = seq;
        f[7:0]  = 8'hA5;
        f[15:8] = seq;
        for (int k = 0; k < SB; k++) begin
            f[16 + 8*k +: 8] = status[8*k +: 8];
            chk              = chk ^ status[8*k +: 8];
        end
        f[8*(SB + 2) +: 8] = chk;
        return f;
    endfunction

    task automatic pushFrame(input logic [15:0] status);
        expQ.push_back(makeFrame(modelSeq, status));
        modelSeq = modelSeq + 8'd1;
    endtask

    task automatic applyStimulus(input logic [15:0] status, input logic req, input logic rst);
        @(posedge clk);
        #2;
        i_status   = status;
        i_send_req = req;
        reset      = rst;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic waitFrameDone();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((o_frame_done !== 1'b1) && (n < 1000));
        checkOutput("frameDoneSeen", 64'(o_frame_done), 64'd1);
        if (o_frame_done !== 1'b1) timedOut = 1'b1;
    endtask

    // Line decoder: samples every cycle, checks each bit is held CPB cycles,
    // start bit low, stop bit high, and compares complete frames.
    bit          rxActive = 1'b0;
    int          rxCycle;
    int          rxBitIdx;
    int          rxPhase;
    int          rxBytes = 0;
    logic [7:0]  rxByte;
    bit          rxTimingOk;
    logic [39:0] rxFrame;
    logic [39:0] expFrame;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            rxActive = 1'b0;
            rxBytes  = 0;
            rxFrame  = '0;
        end else begin
            if (!rxActive && (o_UART_TX === 1'b0)) begin
                rxActive   = 1'b1;
                rxCycle    = 0;
                rxByte     = '0;
                rxTimingOk = 1'b1;
            end
            if (rxActive) begin
                rxBitIdx = rxCycle / CPB;
                rxPhase  = rxCycle % CPB;
                if (rxBitIdx == 0) begin
                    if (o_UART_TX !== 1'b0) rxTimingOk = 1'b0;
                end else if (rxBitIdx <= 8) begin
                    if (rxPhase == 0) rxByte[rxBitIdx-1] = o_UART_TX;
                    else if (o_UART_TX !== rxByte[rxBitIdx-1]) rxTimingOk = 1'b0;
                end else begin
                    if (o_UART_TX !== 1'b1) rxTimingOk = 1'b0;
                end
                rxCycle++;
                if (rxCycle == 10 * CPB) begin
                    rxActive = 1'b0;
                    vectorCount++;
                    if (!rxTimingOk) begin
                        missCount++;
                        $display("[TB] FAIL byteTiming: byte %0d (value %h) not start=0/stop=1 with %0d-cycle bits at %0t",
                                 rxBytes, rxByte, CPB, $time);
                    end
                    rxFrame[8*rxBytes +: 8] = rxByte;
                    rxBytes++;
                    if (rxBytes == FRAME_BYTES) begin
                        rxBytes = 0;
                        vectorCount++;
                        if (expQ.size() == 0) begin
                            missCount++;
                            $display("[TB] FAIL unexpectedFrame: got %h, expected no frame at %0t", rxFrame, $time);
                        end else begin
                            expFrame = expQ.pop_front();
                            if (rxFrame !== expFrame) begin
                                missCount++;
                                $display("[TB] FAIL frameBytes: got %h, expected %h (byte 0 rightmost) at %0t",
                                         rxFrame, expFrame, $time);
                            end
                        end
                    end
                end
            end
        end
    end

    // Busy monitor: every completed frame keeps o_busy high for exactly the
    // frame length and is followed by a one-cycle done pulse.
    int busyRun  = 0;
    bit prevBusy = 1'b0;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            busyRun  = 0;
            prevBusy = 1'b0;
        end else begin
            if (o_busy === 1'b1) begin
                busyRun++;
            end else if (prevBusy) begin
                vectorCount += 2;
                if (busyRun != FRAME_CYCLES) begin
                    missCount++;
                    $display("[TB] FAIL busyLength: got %0d cycles, expected %0d", busyRun, FRAME_CYCLES);
                end
                if (o_frame_done !== 1'b1) begin
                    missCount++;
                    $display("[TB] FAIL donePulse: got %b after busy fell, expected 1", o_frame_done);
                end
                busyRun = 0;
            end else if (o_frame_done !== 1'b0) begin
                vectorCount++;
                missCount++;
                $display("[TB] FAIL spuriousDone: got %b, expected 0 outside frame end at %0t", o_frame_done, $time);
            end
            prevBusy = (o_busy === 1'b1);
        end
    end

    initial begin
        int gap;
        int frames;
        int expectN;
        int mode;
        int mid;

        reset      = 1'b1;
        i_status   = 16'h0000;
        i_send_req = 1'b0;
        modelSeq   = 8'd0;
        curStatus  = 16'h0000;

        // Post-reset frame with an all-zero status.
        pushFrame(16'h0000);
        repeat (3) applyStimulus(16'h0000, 1'b0, 1'b1);
        applyStimulus(16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("resetTx", 64'(o_UART_TX), 64'd1);
        checkOutput("resetBusy", 64'(o_busy), 64'd0);
        checkOutput("resetDone", 64'(o_frame_done), 64'd0);
        @(negedge clk);
        checkOutput("firstStartBit", 64'({o_busy, o_UART_TX}), 64'b10);
        waitFrameDone();

        // Constant status: next frame only at heartbeat expiry.
        pushFrame(16'h0000);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while ((o_UART_TX !== 1'b0) && (gap < 200));
        vectorCount++;
        if ((gap < 64) || (gap > 67)) begin
            missCount++;
            $display("[TB] FAIL heartbeatGap: got %0d cycles from done to start bit, expected 64..67", gap);
        end
        waitFrameDone();

        // Status change while idle.
        curStatus = 16'h1234;
        applyStimulus(curStatus, 1'b0, 1'b0);
        pushFrame(curStatus);
        waitFrameDone();

        // Mid-frame status change plus two requests collapse into one extra frame.
        applyStimulus(curStatus, 1'b1, 1'b0);
        pushFrame(curStatus);
        repeat (30) applyStimulus(curStatus, 1'b0, 1'b0);
        curStatus = 16'h00FF;
        applyStimulus(curStatus, 1'b0, 1'b0);
        applyStimulus(curStatus, 1'b1, 1'b0);
        applyStimulus(curStatus, 1'b0, 1'b0);
        applyStimulus(curStatus, 1'b0, 1'b0);
        applyStimulus(curStatus, 1'b1, 1'b0);
        applyStimulus(curStatus, 1'b0, 1'b0);
        pushFrame(curStatus);
        waitFrameDone();
        @(negedge clk);
        @(negedge clk);
        checkOutput("backToBackStart", 64'({o_busy, o_UART_TX}), 64'b10);
        waitFrameDone();

        // Reset in the middle of the third byte abandons the frame.
        applyStimulus(curStatus, 1'b1, 1'b0);
        repeat (90) applyStimulus(curStatus, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midFrameBusy", 64'(o_busy), 64'd1);
        applyStimulus(curStatus, 1'b0, 1'b1);
        modelSeq = 8'd0;
        pushFrame(curStatus);
        applyStimulus(curStatus, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("abortTx", 64'(o_UART_TX), 64'd1);
        checkOutput("abortBusy", 64'(o_busy), 64'd0);
        waitFrameDone();

        // Randomized triggers; 256+ frames wrap seq through FF -> 00.
        frames = 0;
        while ((frames < 256) && !timedOut) begin
            repeat ($urandom_range(0, 20)) applyStimulus(curStatus, 1'b0, 1'b0);
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                curStatus = curStatus ^ 16'($urandom_range(1, 65535));
                applyStimulus(curStatus, 1'b0, 1'b0);
            end else if (mode == 1) begin
                applyStimulus(curStatus, 1'b1, 1'b0);
                applyStimulus(curStatus, 1'b0, 1'b0);
            end else begin
                curStatus = 16'($urandom);
                applyStimulus(curStatus, 1'b1, 1'b0);
                applyStimulus(curStatus, 1'b0, 1'b0);
            end
            pushFrame(curStatus);
            expectN = 1;
            mid = $urandom_range(0, 3);
            if (mid == 1) begin
                repeat ($urandom_range(5, 60)) applyStimulus(curStatus, 1'b0, 1'b0);
                applyStimulus(curStatus, 1'b1, 1'b0);
                applyStimulus(curStatus, 1'b0, 1'b0);
                if ($urandom_range(0, 1) == 1) begin
                    applyStimulus(curStatus, 1'b1, 1'b0);
                    applyStimulus(curStatus, 1'b0, 1'b0);
                end
                pushFrame(curStatus);
                expectN = 2;
            end else if (mid == 2) begin
                repeat ($urandom_range(5, 60)) applyStimulus(curStatus, 1'b0, 1'b0);
                curStatus = curStatus ^ 16'($urandom_range(1, 65535));
                applyStimulus(curStatus, 1'b0, 1'b0);
                pushFrame(curStatus);
                expectN = 2;
            end
            repeat (expectN) begin
                if (!timedOut) waitFrameDone();
            end
            frames += expectN;
        end

        repeat (3) @(negedge clk);
        checkOutput("framesOutstanding", 64'(expQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
